cnn_mac_pipe: RTL and testbench

Parametrised multi-lane signed multiply-accumulate pipeline for the lane CNN convolution datapath. It replaces a single fixed-width multiplier with LANES parallel signed multipliers, an adder tree and a grouped accumulator. Each output value is rounded, shifted and saturated. It sits between the feature/weight line buffers and the activation stage, and uses valid/ready handshakes on both sides.

---
 rtl/cnn_mac_pkg.sv | 53 +++++
 rtl/cnn_mac_mul_lane.sv | 34 +++
 rtl/cnn_mac_pipe.sv | 143 ++++++++++++++
 tb/tb_cnn_mac_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_mac_pkg.sv
// Shared types and helpers for the multi-lane signed MAC pipeline.
// round_shift_sat works on a wide signed container so one function serves any legal ACC_W/OUT_W.
package cnn_mac_pkg;

    localparam int RSS_W      = 128;
    localparam int DATA_MAX_W = 64;

    typedef struct packed {
        logic                  sat;
        logic [DATA_MAX_W-1:0] data;
    } rss_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_ctl_t;

    function automatic int tree_w(input int a_w, input int b_w, input int lanes);
        return a_w + b_w + $clog2(lanes);
    endfunction

    function automatic bit params_ok(input int a_w, input int b_w, input int lanes,
                                     input int mul_stages, input int acc_w,
                                     input int out_w, input int shift);
        return (lanes >= 1) && (mul_stages >= 1) && (a_w >= 1) && (b_w >= 1) &&
               (acc_w >= tree_w(a_w, b_w, lanes)) && (acc_w < RSS_W) &&
               (out_w >= 2) && (out_w < DATA_MAX_W) && (shift >= 0) && (shift < acc_w);
    endfunction

    // acc is the sign-extended accumulator; the wide container cannot overflow when adding the rounding bit.
    function automatic rss_t round_shift_sat(input logic signed [RSS_W-1:0] acc,
                                             input int shift, input int out_w);
        logic signed [RSS_W-1:0] rnd;
        logic signed [RSS_W-1:0] r;
        logic signed [RSS_W-1:0] hi;
        logic signed [RSS_W-1:0] lo;
        rss_t                    res;
        rnd      = (shift > 0) ? (RSS_W'(1) << (shift - 1)) : '0;
        r        = (acc + rnd) >>> shift;
        hi       = (RSS_W'(1) << (out_w - 1)) - RSS_W'(1);
        lo       = ~hi;
        res.sat  = (r > hi) || (r < lo);
        if (r > hi)
            res.data = hi[DATA_MAX_W-1:0];
        else if (r < lo)
            res.data = lo[DATA_MAX_W-1:0];
        else
            res.data = r[DATA_MAX_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/cnn_mac_mul_lane.sv
// One signed A_W x B_W multiplier lane with STAGES enable-gated register stages.
module cnn_mac_mul_lane
    import cnn_mac_pkg::*;
#(
    parameter int A_W    = 16,
    parameter int B_W    = 6,
    parameter int STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic signed [A_W-1:0]      a,
    input  logic signed [B_W-1:0]      b,
    output logic signed [A_W+B_W-1:0]  p
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++)
                stage_q[i] <= '0;
        end else if (en) begin
            stage_q[0] <= P_W'(a) * P_W'(b);
            for (int i = 1; i < STAGES; i++)
                stage_q[i] <= stage_q[i-1];
        end
    end

    assign p = stage_q[STAGES-1];

endmodule

// File: rtl/cnn_mac_pipe.sv
// Multi-lane signed MAC: input regs, per-lane multipliers, adder tree, grouped accumulator, round/shift/saturate.
// The whole pipe advances on a single enable so backpressure freezes every stage together.
module cnn_mac_pipe
    import cnn_mac_pkg::*;
#(
    parameter int A_W        = 16,
    parameter int B_W        = 6,
    parameter int LANES      = 4,
    parameter int MUL_STAGES = 2,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*A_W-1:0]     in_a,
    input  logic [LANES*B_W-1:0]     in_b,
    input  logic                     in_first,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat
);

    localparam int  P_W       = A_W + B_W;
    localparam int  TREE_W    = tree_w(A_W, B_W, LANES);
    localparam bit  PARAMS_OK = params_ok(A_W, B_W, LANES, MUL_STAGES, ACC_W, OUT_W, SHIFT);

    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("cnn_mac_pipe: illegal parameter set");
        end
    endgenerate

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic [LANES*A_W-1:0] a_q;
    logic [LANES*B_W-1:0] b_q;
    beat_ctl_t            ctl_q [MUL_STAGES+1];

    // ctl_q[0] is S0; ctl_q[MUL_STAGES] lines up with the multiplier outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
            for (int i = 0; i <= MUL_STAGES; i++)
                ctl_q[i] <= '0;
        end else if (adv) begin
            a_q      <= in_a;
            b_q      <= in_b;
            ctl_q[0] <= '{valid: in_valid, first: in_first, last: in_last};
            for (int i = 1; i <= MUL_STAGES; i++)
                ctl_q[i] <= ctl_q[i-1];
        end
    end

    logic signed [P_W-1:0] prod [LANES];

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            cnn_mac_mul_lane #(
                .A_W    (A_W),
                .B_W    (B_W),
                .STAGES (MUL_STAGES)
            ) u_mul (
                .clk     (clk),
                .reset_n (reset_n),
                .en      (adv),
                .a       (a_q[g*A_W +: A_W]),
                .b       (b_q[g*B_W +: B_W]),
                .p       (prod[g])
            );
        end
    endgenerate

    logic signed [TREE_W-1:0] tree_sum;
    logic signed [TREE_W-1:0] tree_q;
    beat_ctl_t                t_ctl;

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++)
            tree_sum = tree_sum + TREE_W'(prod[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tree_q <= '0;
            t_ctl  <= '0;
        end else if (adv) begin
            tree_q <= tree_sum;
            t_ctl  <= ctl_q[MUL_STAGES];
        end
    end

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_base;
    logic                    grp_open;
    logic                    res_pend;

    // A group restarts on an explicit first or whenever the previous committed beat closed one.
    assign acc_base = (t_ctl.first || !grp_open) ? '0 : acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            grp_open <= 1'b0;
            res_pend <= 1'b0;
        end else if (adv) begin
            res_pend <= t_ctl.valid && t_ctl.last;
            if (t_ctl.valid) begin
                acc      <= acc_base + ACC_W'(tree_q);
                grp_open <= !t_ctl.last;
            end
        end
    end

    rss_t                       rss;
    logic [DATA_MAX_W-OUT_W-1:0] unused_rss_hi;

    assign rss           = round_shift_sat(RSS_W'(acc), SHIFT, OUT_W);
    assign unused_rss_hi = rss.data[DATA_MAX_W-1:OUT_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            out_valid <= res_pend;
            if (res_pend) begin
                out_data <= rss.data[OUT_W-1:0];
                out_sat  <= rss.sat;
            end
        end
    end

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Directed and randomized checks of cnn_mac_pipe against an arithmetic reference model.
module tb_cnn_mac_pipe;

    localparam int A_W        = 16;
    localparam int B_W        = 6;
    localparam int LANES      = 4;
    localparam int MUL_STAGES = 2;
    localparam int ACC_W      = 32;
    localparam int OUT_W      = 16;
    localparam int SHIFT      = 4;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*A_W-1:0]    in_a;
    logic [LANES*B_W-1:0]    in_b;
    logic                    in_first;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_sat;

    cnn_mac_pipe #(
        .A_W(A_W), .B_W(B_W), .LANES(LANES), .MUL_STAGES(MUL_STAGES),
        .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit sat;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   m_acc = 0;
    bit   m_open = 1'b0;
    bit   chk_lat = 1'b0;
    int   last_data = 0;
    bit   last_sat = 1'b0;
    int   n_pops = 0;
    int   stall_left = 0;

    function automatic exp_t ref_result(input int acc);
        longint v, r, hi, lo;
        exp_t   e;
        v      = longint'(acc);
        r      = (v + ((SHIFT > 0) ? (longint'(1) <<< (SHIFT - 1)) : 64'sd0)) >>> SHIFT;
        hi     = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo     = -hi - 1;
        e.sat  = (r > hi) || (r < lo);
        e.data = int'((r > hi) ? hi : ((r < lo) ? lo : r));
        e.cyc  = 0;
        return e;
    endfunction

    function automatic void model_accept();
        int   sum;
        exp_t e;
        sum = 0;
        for (int i = 0; i < LANES; i++)
            sum += int'($signed(in_a[i*A_W +: A_W])) * int'($signed(in_b[i*B_W +: B_W]));
        if (in_first || !m_open)
            m_acc = 0;
        m_acc  = m_acc + sum;
        m_open = !in_last;
        if (in_last) begin
            e     = ref_result(m_acc);
            e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
    endfunction

    task automatic tick(output bit accepted);
        exp_t e;
        @(negedge clk);
        accepted = in_valid && in_ready;
        if (out_valid && !out_ready) begin
            checks++;
            assert (in_ready === 1'b0) else begin
                errors++;
                $error("FAIL stall_in_ready observed %b expected 0", in_ready);
            end
        end
        if (out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL spurious_result observed data %0d expected no result", out_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (int'(out_data) === e.data) else begin
                    errors++;
                    $error("FAIL out_data observed %0d expected %0d", out_data, e.data);
                end
                checks++;
                assert (out_sat === e.sat) else begin
                    errors++;
                    $error("FAIL out_sat observed %b expected %b", out_sat, e.sat);
                end
                if (chk_lat) begin
                    checks++;
                    assert (cyc - e.cyc === MUL_STAGES + 3) else begin
                        errors++;
                        $error("FAIL latency observed %0d expected %0d", cyc - e.cyc, MUL_STAGES + 3);
                    end
                end
            end
            last_data = int'(out_data);
            last_sat  = out_sat;
            n_pops++;
        end
        if (accepted)
            model_accept();
        @(posedge clk);
        cyc++;
        #1;
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++)
            tick(acc);
    endtask

    task automatic send(input int av[LANES], input int bv[LANES], input bit f, input bit l);
        bit done;
        done = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            in_a[i*A_W +: A_W] = A_W'(av[i]);
            in_b[i*B_W +: B_W] = B_W'(bv[i]);
        end
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++)
            tick(done);
        checks++;
        assert (done === 1'b1) else begin
            errors++;
            $error("FAIL accept_timeout observed %b expected 1", done);
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_last(input string tag, input int d, input bit s, input int pops_before);
        checks++;
        assert (n_pops === pops_before + 1) else begin
            errors++;
            $error("FAIL %s_count observed %0d expected %0d", tag, n_pops - pops_before, 1);
        end
        checks++;
        assert (last_data === d) else begin
            errors++;
            $error("FAIL %s_data observed %0d expected %0d", tag, last_data, d);
        end
        checks++;
        assert (last_sat === s) else begin
            errors++;
            $error("FAIL %s_sat observed %b expected %b", tag, last_sat, s);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        assert (out_valid === 1'b0) else begin
            errors++; $error("FAIL %s_out_valid observed %b expected 0", tag, out_valid);
        end
        checks++;
        assert (out_data === '0) else begin
            errors++; $error("FAIL %s_out_data observed %0d expected 0", tag, out_data);
        end
        checks++;
        assert (out_sat === 1'b0) else begin
            errors++; $error("FAIL %s_out_sat observed %b expected 0", tag, out_sat);
        end
        checks++;
        assert (in_ready === 1'b1) else begin
            errors++; $error("FAIL %s_in_ready observed %b expected 1", tag, in_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p;
        int av[LANES];
        int bv[LANES];
        bit f, l;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #2 reset_n = 1'b1;

        chk_lat = 1'b1;

        p = n_pops;
        send('{100, -200, 300, -400}, '{3, 3, 3, 3}, 1'b1, 1'b1);
        idle(8);
        expect_last("single_beat", -37, 1'b0, p);

        p = n_pops;
        send('{1, 1, 1, 1}, '{4, 4, 4, 4}, 1'b1, 1'b0);
        idle(7);
        send('{1, 1, 1, 1}, '{4, 4, 4, 4}, 1'b0, 1'b0);
        idle(7);
        checks++;
        assert (n_pops === p) else begin
            errors++; $error("FAIL group_early_output observed %0d expected 0", n_pops - p);
        end
        send('{1, 1, 1, 1}, '{4, 4, 4, 4}, 1'b0, 1'b1);
        idle(8);
        expect_last("three_beat", 3, 1'b0, p);

        p = n_pops;
        send('{-32768, -32768, -32768, -32768}, '{-32, -32, -32, -32}, 1'b1, 1'b1);
        idle(8);
        expect_last("sat_pos", 32767, 1'b1, p);
        p = n_pops;
        send('{32767, 32767, 32767, 32767}, '{-32, -32, -32, -32}, 1'b1, 1'b1);
        idle(8);
        expect_last("sat_neg", -32768, 1'b1, p);

        p = n_pops;
        send('{-8, 0, 0, 0}, '{1, 0, 0, 0}, 1'b1, 1'b1);
        idle(8);
        expect_last("round_m8", 0, 1'b0, p);
        p = n_pops;
        send('{-9, 0, 0, 0}, '{1, 0, 0, 0}, 1'b1, 1'b1);
        idle(8);
        expect_last("round_m9", -1, 1'b0, p);
        p = n_pops;
        send('{8, 0, 0, 0}, '{1, 0, 0, 0}, 1'b1, 1'b1);
        idle(8);
        expect_last("round_p8", 1, 1'b0, p);

        chk_lat = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (n == 8)
                stall_left = 10;
            if ($urandom_range(0, 3) == 0)
                idle(1);
            for (int i = 0; i < LANES; i++) begin
                av[i] = int'($urandom_range(0, 65535)) - 32768;
                bv[i] = int'($urandom_range(0, 63)) - 32;
            end
            f = ($urandom_range(0, 3) == 0);
            l = (n == 7) ? 1'b1 : 1'(($urandom_range(0, 1)));
            send(av, bv, f, l);
        end
        idle(15);
        checks++;
        assert (exp_q.size() === 0) else begin
            errors++; $error("FAIL stream_drain observed %0d pending expected 0", exp_q.size());
        end

        send('{100, -200, 300, -400}, '{3, 3, 3, 3}, 1'b1, 1'b1);
        idle(3);
        send('{1, 1, 1, 1}, '{4, 4, 4, 4}, 1'b1, 1'b0);
        send('{1, 1, 1, 1}, '{4, 4, 4, 4}, 1'b0, 1'b0);
        checks++;
        assert (out_valid === 1'b1) else begin
            errors++; $error("FAIL pre_reset_valid observed %b expected 1", out_valid);
        end
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        m_acc  = 0;
        m_open = 1'b0;
        #2 reset_n = 1'b1;

        p = n_pops;
        send('{4, 0, 0, 0}, '{4, 0, 0, 0}, 1'b0, 1'b1);
        idle(8);
        expect_last("post_reset_nonfirst", 1, 1'b0, p);
        p = n_pops;
        send('{4, 0, 0, 0}, '{4, 0, 0, 0}, 1'b1, 1'b1);
        idle(8);
        expect_last("post_reset", 1, 1'b0, p);

        checks++;
        assert (exp_q.size() === 0) else begin
            errors++; $error("FAIL final_drain observed %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
